// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the accum_seq sequential accumulator:
// FSM state encoding, sequence length and the order in which terms are summed.
package accum_seq_pkg;

  localparam int NTERMS = 8;
  localparam int NSEZ   = 6;
  localparam int CNT_W  = $clog2(NTERMS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Position of each operand in the summation; SEZ taps after the sixth term.
  typedef enum logic [CNT_W-1:0] {
    TERM_WB1 = 3'd0,
    TERM_WB2 = 3'd1,
    TERM_WB3 = 3'd2,
    TERM_WB4 = 3'd3,
    TERM_WB5 = 3'd4,
    TERM_WB6 = 3'd5,
    TERM_WA2 = 3'd6,
    TERM_WA1 = 3'd7
  } term_e;

  localparam logic [CNT_W-1:0] CNT_SEZ = CNT_W'(NSEZ - 1);
  localparam logic [CNT_W-1:0] CNT_SE  = CNT_W'(NTERMS - 1);

endpackage

// File: rtl/accum_seq_dp.sv
// Datapath: captured operand bank, term select mux, adder and wrapping accumulator.
// sum_hi_o exposes the upper bits of (acc + current term) for the estimate registers.
module accum_seq_dp
  import accum_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     add_i,
  input  logic [CNT_W-1:0]         sel_i,
  input  logic [NTERMS*WIDTH-1:0]  ops_i,
  output logic [WIDTH-2:0]         sum_hi_o
);

  logic [WIDTH-1:0] ops_q [NTERMS];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] sum;

  // NOTE: operand bank has no reset; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (load_i) begin
      for (int i = 0; i < NTERMS; i++) begin
        ops_q[i] <= ops_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign term     = ops_q[sel_i];
  assign sum      = acc_q + term;
  assign sum_hi_o = sum[WIDTH-1:1];

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/accum_seq.sv
// Sequential eight-term accumulator producing the SEZ and SE estimates.
// Holds the FSM, term counter and estimate registers; arithmetic lives in accum_seq_dp.
module accum_seq
  import accum_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  input  logic             scan_enable,
  input  logic             test_mode,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4,
  input  logic             req,
  input  logic [WIDTH-1:0] WB1,
  input  logic [WIDTH-1:0] WB2,
  input  logic [WIDTH-1:0] WB3,
  input  logic [WIDTH-1:0] WB4,
  input  logic [WIDTH-1:0] WB5,
  input  logic [WIDTH-1:0] WB6,
  input  logic [WIDTH-1:0] WA2,
  input  logic [WIDTH-1:0] WA1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-2:0] SEZ,
  output logic [WIDTH-2:0] SE
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-2:0]       sez_q, sez_d;
  logic [WIDTH-2:0]       se_q, se_d;
  logic                   load;
  logic                   add_en;
  logic [WIDTH-2:0]       sum_hi;
  logic [NTERMS*WIDTH-1:0] ops;

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req) state_d = ST_ADD;
      ST_ADD:  if (cnt_q == CNT_SE) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    add_en = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      ST_IDLE: load = req;
      ST_ADD: begin
        busy   = 1'b1;
        add_en = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    sez_d = sez_q;
    se_d  = se_q;
    if (load) begin
      cnt_d = '0;
    end else if (add_en) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_SEZ) sez_d = sum_hi;
      if (cnt_q == CNT_SE)  se_d  = sum_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sez_q <= '0;
      se_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sez_q <= sez_d;
      se_q  <= se_d;
    end
  end

  always_comb begin
    ops = '0;
    ops[int'(TERM_WB1)*WIDTH +: WIDTH] = WB1;
    ops[int'(TERM_WB2)*WIDTH +: WIDTH] = WB2;
    ops[int'(TERM_WB3)*WIDTH +: WIDTH] = WB3;
    ops[int'(TERM_WB4)*WIDTH +: WIDTH] = WB4;
    ops[int'(TERM_WB5)*WIDTH +: WIDTH] = WB5;
    ops[int'(TERM_WB6)*WIDTH +: WIDTH] = WB6;
    ops[int'(TERM_WA2)*WIDTH +: WIDTH] = WA2;
    ops[int'(TERM_WA1)*WIDTH +: WIDTH] = WA1;
  end

  accum_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (load),
    .add_i    (add_en),
    .sel_i    (cnt_q),
    .ops_i    (ops),
    .sum_hi_o (sum_hi)
  );

  assign SEZ = sez_q;
  assign SE  = se_q;

  // Scan chains are stitched at DFT insertion; outputs stay low in functional mode.
  assign scan_out0 = test_mode & scan_enable & scan_in0;
  assign scan_out1 = test_mode & scan_enable & scan_in1;
  assign scan_out2 = test_mode & scan_enable & scan_in2;
  assign scan_out3 = test_mode & scan_enable & scan_in3;
  assign scan_out4 = test_mode & scan_enable & scan_in4;

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq: reset, arithmetic cases, estimate timing,
// back-to-back requests with operand changes, and reset abort mid-sequence.
module tb_accum_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic             scan_enable, test_mode;
  logic             scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic             req;
  logic [WIDTH-1:0] WB1, WB2, WB3, WB4, WB5, WB6, WA2, WA1;
  logic             busy, done;
  logic [WIDTH-2:0] SEZ, SE;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  accum_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .req(req),
    .WB1(WB1), .WB2(WB2), .WB3(WB3), .WB4(WB4), .WB5(WB5), .WB6(WB6),
    .WA2(WA2), .WA1(WA1),
    .busy(busy), .done(done), .SEZ(SEZ), .SE(SE)
  );

  task automatic set_ops(input logic [15:0] b1, b2, b3, b4, b5, b6, a2, a1);
    WB1 = b1; WB2 = b2; WB3 = b3; WB4 = b4; WB5 = b5; WB6 = b6; WA2 = a2; WA1 = a1;
  endtask

  // Pulse req from a negedge and return the number of edges until done is seen
  // (0 on timeout) plus whether busy stayed high throughout.
  task automatic run_seq(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    req     = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 1'b1;
    scan_in0 = 1'b1; scan_in1 = 1'b1; scan_in2 = 1'b1; scan_in3 = 1'b1; scan_in4 = 1'b1;
    scan_enable = 1'b1;
    test_mode   = 1'b0;
    set_ops(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (SEZ !== 15'h0) begin errors++; $display("FAIL reset_sez: got %h expected 0000", SEZ); end
    checks++;
    if (SE !== 15'h0) begin errors++; $display("FAIL reset_se: got %h expected 0000", SE); end
    checks++;
    if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b0) begin
      errors++;
      $display("FAIL scan_func_mode: got %b expected 00000",
               {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
    end
    req   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
  endtask

  task automatic test_zero();
    int lat; bit busy_ok;
    set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    run_seq(lat, busy_ok);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL zero_latency: got %0d expected 9", lat); end
    checks++;
    if (busy_ok !== 1'b1) begin errors++; $display("FAIL zero_busy_window: got %b expected 1", busy_ok); end
    checks++;
    if (SEZ !== 15'h0) begin errors++; $display("FAIL zero_sez: got %h expected 0000", SEZ); end
    checks++;
    if (SE !== 15'h0) begin errors++; $display("FAIL zero_se: got %h expected 0000", SE); end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_done_pulse: busy,done got %b expected 00", {busy, done}); end
  endtask

  task automatic test_small();
    int lat; bit busy_ok;
    set_ops(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3);
    run_seq(lat, busy_ok);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL small_latency: got %0d expected 9", lat); end
    checks++;
    if (SEZ !== 15'd3) begin errors++; $display("FAIL small_sez: got %h expected 0003", SEZ); end
    checks++;
    if (SE !== 15'd5) begin errors++; $display("FAIL small_se: got %h expected 0005", SE); end
    set_ops(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
    repeat (5) @(negedge clk);
    checks++;
    if ({SEZ, SE} !== {15'd3, 15'd5}) begin
      errors++; $display("FAIL small_hold: got %h/%h expected 0003/0005", SEZ, SE);
    end
  endtask

  // SEZ must change at the sixth add (edge 7), SE only at the last (edge 9).
  task automatic test_estimate_timing();
    bit seen_done_early = 1'b0;
    set_ops(16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd4, 16'd6);
    req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (k < 9 && done === 1'b1) seen_done_early = 1'b1;
      if (k == 6) begin
        checks++;
        if (SEZ !== 15'd3) begin errors++; $display("FAIL sez_before_tap: got %h expected 0003", SEZ); end
      end
      if (k == 7) begin
        checks++;
        if (SEZ !== 15'd6) begin errors++; $display("FAIL sez_at_tap: got %h expected 0006", SEZ); end
        checks++;
        if (SE !== 15'd5) begin errors++; $display("FAIL se_held_mid: got %h expected 0005", SE); end
      end
      if (k == 9) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL timing_done: got %b expected 1", done); end
        checks++;
        if (SE !== 15'd11) begin errors++; $display("FAIL se_at_end: got %h expected 000b", SE); end
      end
    end
    checks++;
    if (seen_done_early !== 1'b0) begin errors++; $display("FAIL early_done: got %b expected 0", seen_done_early); end
    @(negedge clk);
  endtask

  task automatic test_negative();
    int lat; bit busy_ok;
    set_ops(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001);
    run_seq(lat, busy_ok);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL neg_latency: got %0d expected 9", lat); end
    checks++;
    if (SEZ !== 15'h7FFF) begin errors++; $display("FAIL neg_sez: got %h expected 7fff", SEZ); end
    checks++;
    if (SE !== 15'h0) begin errors++; $display("FAIL neg_se: got %h expected 0000", SE); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int lat; bit busy_ok;
    set_ops(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0);
    run_seq(lat, busy_ok);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL wrap_latency: got %0d expected 9", lat); end
    checks++;
    if (SEZ !== 15'h4000) begin errors++; $display("FAIL wrap_sez: got %h expected 4000", SEZ); end
    checks++;
    if (SE !== 15'h4000) begin errors++; $display("FAIL wrap_se: got %h expected 4000", SE); end
    @(negedge clk);
  endtask

  // req held high: accepts at edges 1 and 11, done at 9 and 19; operands
  // changed right after each acceptance must not leak into the results.
  task automatic test_back_to_back();
    int n_done = 0;
    set_ops(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3);
    req = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) set_ops(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd0, 16'd1);
      if (k == 11) set_ops(16'h7777, 16'h1234, 16'h0F0F, 16'h5555, 16'h2222, 16'h9999, 16'h4321, 16'h8888);
      if (done === 1'b1) n_done++;
      if (k == 9) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done); end
        checks++;
        if ({SEZ, SE} !== {15'd3, 15'd5}) begin
          errors++; $display("FAIL b2b_first_result: got %h/%h expected 0003/0005", SEZ, SE);
        end
      end
      if (k == 10) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy got %b expected 0", busy); end
      end
      if (k == 19) begin
        req = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", done); end
        checks++;
        if ({SEZ, SE} !== {15'd9, 15'd9}) begin
          errors++; $display("FAIL b2b_second_result: got %h/%h expected 0009/0009", SEZ, SE);
        end
      end
    end
    checks++;
    if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
  endtask

  task automatic test_abort();
    int lat; bit busy_ok;
    bit saw_done = 1'b0;
    set_ops(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0);
    req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (done === 1'b1) saw_done = 1'b1;
      if (k == 4) begin
        reset = 1'b0;
        req   = 1'b1;
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if ({SEZ, SE} !== 30'h0) begin errors++; $display("FAIL abort_estimates: got %h/%h expected 0000/0000", SEZ, SE); end
    req   = 1'b0;
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
    set_ops(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3);
    run_seq(lat, busy_ok);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL abort_recover_latency: got %0d expected 9", lat); end
    checks++;
    if ({SEZ, SE} !== {15'd3, 15'd5}) begin
      errors++; $display("FAIL abort_recover_result: got %h/%h expected 0003/0005", SEZ, SE);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_small();
    test_estimate_timing();
    test_negative();
    test_wrap();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
